// File: rtl/store_merge_unit.sv
// Store-path merge unit: issues sw directly, and runs read-modify-write for sh/sb.
// Optional STORE_ALIGN_CHECK_EN: misaligned sw/sh complete at once with align_exc, no memory access.
module store_merge_unit #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  store_type,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        align_exc
);

  localparam logic [1:0] ST_SW    = 2'b00;
  localparam logic [1:0] ST_SH    = 2'b01;
  localparam logic [1:0] ST_SB    = 2'b10;
  localparam logic [1:0] CNT_LAST = 2'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic [1:0]  type_reg, type_next;
  logic [1:0]  lane_reg, lane_next;
  logic [15:0] sd_reg, sd_next;
  logic [31:0] mem_addr_reg, mem_addr_next;
  logic [31:0] mem_wdata_reg, mem_wdata_next;
  logic        mem_wr_reg, mem_wr_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        align_exc_reg, align_exc_next;

  logic [31:0] sh_word;
  logic [31:0] sb_word;
  logic [31:0] merged_word;

  // Lane n is bits 8n+7:8n; each lane takes store data or keeps the read word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign sb_word[8*gi +: 8] = (lane_reg == 2'(gi)) ? sd_reg[7:0]
                                                     : mem_rdata[8*gi +: 8];
    assign sh_word[8*gi +: 8] = (lane_reg[1] == 1'(gi / 2)) ? sd_reg[8*(gi % 2) +: 8]
                                                            : mem_rdata[8*gi +: 8];
  end

  assign merged_word = (type_reg == ST_SB) ? sb_word : sh_word;

`ifdef STORE_ALIGN_CHECK_EN
  logic misalign;
  assign misalign = ((store_type == ST_SW) && (addr[1:0] != 2'b00)) ||
                    ((store_type == ST_SH) && addr[0]);
`endif

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    type_next      = type_reg;
    lane_next      = lane_reg;
    sd_next        = sd_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    align_exc_next = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          type_next     = store_type;
          lane_next     = addr[1:0];
          sd_next       = store_data[15:0];
          mem_addr_next = {addr[31:2], 2'b00};
          cnt_next      = 2'd0;
`ifdef STORE_ALIGN_CHECK_EN
          if (misalign) begin
            state_next     = S_DONE;
            align_exc_next = 1'b1;
          end else
`endif
          begin
            case (store_type)
              ST_SW: begin
                state_next     = S_WRITE;
                mem_wdata_next = store_data;
              end
              ST_SH, ST_SB: state_next = S_READ;
              default:      state_next = S_DONE;
            endcase
          end
        end
      end
      S_READ: begin
        state_next = S_WAIT;
        cnt_next   = 2'd0;
      end
      S_WAIT: begin
        // Read data is valid in the final wait cycle; merge it straight into the write word.
        if (cnt_reg == CNT_LAST) begin
          state_next     = S_WRITE;
          mem_wdata_next = merged_word;
        end else begin
          cnt_next = cnt_reg + 2'd1;
        end
      end
      S_WRITE: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state itself.
  assign mem_wr_next = (state_next == S_WRITE);
  assign busy_next   = (state_next == S_READ) || (state_next == S_WAIT) ||
                       (state_next == S_WRITE);
  assign done_next   = (state_next == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= 2'd0;
      type_reg      <= 2'd0;
      lane_reg      <= 2'd0;
      sd_reg        <= 16'd0;
      mem_addr_reg  <= 32'd0;
      mem_wdata_reg <= 32'd0;
      mem_wr_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      align_exc_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      type_reg      <= type_next;
      lane_reg      <= lane_next;
      sd_reg        <= sd_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_wr_reg    <= mem_wr_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      align_exc_reg <= align_exc_next;
    end
  end

  assign mem_addr  = mem_addr_reg;
  assign mem_wr    = mem_wr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign align_exc = align_exc_reg;

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit (MEM_LAT=1) with a one-cycle-latency word memory.
module tb_store_merge_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  store_type;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        align_exc;

  logic [31:0] mem [0:255];
  logic [31:0] rd_pipe = 32'd0;
  int          wr_count = 0;
  int          wr_base;
  int          compares = 0;
  int          mismatches = 0;

  store_merge_unit #(.MEM_LAT(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .store_type (store_type),
    .addr       (addr),
    .store_data (store_data),
    .mem_rdata  (mem_rdata),
    .mem_addr   (mem_addr),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .align_exc  (align_exc)
  );

  always #5 clk = ~clk;

  // Memory returns the word at mem_addr one cycle after it is presented.
  always @(posedge clk) rd_pipe <= mem[mem_addr[9:2]];
  assign mem_rdata = rd_pipe;

  always @(posedge clk) if (mem_wr) wr_count <= wr_count + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      mismatches++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    store_type = t;
    addr       = a;
    store_data = d;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[8'h40] = 32'h11223344;
    mem[8'h80] = 32'h55667788;
    reset = 1'b1; start = 1'b0; store_type = 2'b00; addr = 32'd0; store_data = 32'd0;
    tick(); tick();
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_align_exc", 32'(align_exc), 32'd0);
    reset = 1'b0;
    tick();

    // sw: write in k+1, done in k+2
    wr_base = wr_count;
    go(2'b00, 32'h100, 32'hDEADBEEF);
    check("sw_wr", 32'(mem_wr), 32'd1);
    check("sw_addr", mem_addr, 32'h100);
    check("sw_wdata", mem_wdata, 32'hDEADBEEF);
    check("sw_busy", 32'(busy), 32'd1);
    check("sw_done_early", 32'(done), 32'd0);
    tick();
    check("sw_done", 32'(done), 32'd1);
    check("sw_busy_done", 32'(busy), 32'd0);
    check("sw_wr_off", 32'(mem_wr), 32'd0);
    check("sw_wr_count", 32'(wr_count - wr_base), 32'd1);
    tick();

    // sb lane 3
    wr_base = wr_count;
    go(2'b10, 32'h103, 32'h000000AA);
    check("sb_read_addr", mem_addr, 32'h100);
    check("sb_read_wr", 32'(mem_wr), 32'd0);
    check("sb_read_busy", 32'(busy), 32'd1);
    tick();
    check("sb_wait_wr", 32'(mem_wr), 32'd0);
    tick();
    check("sb_wr", 32'(mem_wr), 32'd1);
    check("sb_wdata", mem_wdata, 32'hAA223344);
    check("sb_addr", mem_addr, 32'h100);
    tick();
    check("sb_done", 32'(done), 32'd1);
    check("sb_align_exc", 32'(align_exc), 32'd0);
    check("sb_wr_count", 32'(wr_count - wr_base), 32'd1);
    tick();

    // sh upper half
    go(2'b01, 32'h202, 32'h1234ABCD);
    tick(); tick();
    check("sh_hi_wr", 32'(mem_wr), 32'd1);
    check("sh_hi_wdata", mem_wdata, 32'hABCD7788);
    check("sh_hi_addr", mem_addr, 32'h200);
    tick();
    check("sh_hi_done", 32'(done), 32'd1);
    tick();

    // sh lower half
    go(2'b01, 32'h200, 32'h1234ABCD);
    tick(); tick();
    check("sh_lo_wdata", mem_wdata, 32'h5566ABCD);
    tick();
    check("sh_lo_done", 32'(done), 32'd1);
    tick();

    // sb lane 1 with a second start and changed inputs mid-operation
    wr_base = wr_count;
    go(2'b10, 32'h101, 32'h00000055);
    store_data = 32'hFFFFFFFF;
    addr       = 32'h300;
    tick();
    store_type = 2'b00;
    start      = 1'b1;
    tick();
    start = 1'b0;
    check("busy_ign_wr", 32'(mem_wr), 32'd1);
    check("busy_ign_wdata", mem_wdata, 32'h11225544);
    check("busy_ign_addr", mem_addr, 32'h100);
    tick();
    check("busy_ign_done", 32'(done), 32'd1);
    tick();
    check("busy_ign_idle", 32'(busy), 32'd0);
    tick(); tick();
    check("busy_ign_wr_count", 32'(wr_count - wr_base), 32'd1);

    // reset during WAIT
    wr_base = wr_count;
    go(2'b10, 32'h100, 32'h00000077);
    tick();
    check("rstw_in_wait", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstw_busy", 32'(busy), 32'd0);
    check("rstw_wr", 32'(mem_wr), 32'd0);
    check("rstw_done", 32'(done), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rstw_no_wr", 32'(mem_wr), 32'd0);
      check("rstw_no_done", 32'(done), 32'd0);
    end
    check("rstw_wr_count", 32'(wr_count - wr_base), 32'd0);

    // reserved type
    wr_base = wr_count;
    go(2'b11, 32'h100, 32'h12345678);
    check("rsv_done", 32'(done), 32'd1);
    check("rsv_wr", 32'(mem_wr), 32'd0);
    check("rsv_busy", 32'(busy), 32'd0);
    tick();
    check("rsv_wr_count", 32'(wr_count - wr_base), 32'd0);
    tick();

    // misaligned sw
    wr_base = wr_count;
    go(2'b00, 32'h101, 32'hCAFEF00D);
`ifdef STORE_ALIGN_CHECK_EN
    check("mis_sw_done", 32'(done), 32'd1);
    check("mis_sw_exc", 32'(align_exc), 32'd1);
    check("mis_sw_wr", 32'(mem_wr), 32'd0);
    tick();
    check("mis_sw_exc_clr", 32'(align_exc), 32'd0);
    check("mis_sw_wr_count", 32'(wr_count - wr_base), 32'd0);
    tick();
    go(2'b01, 32'h201, 32'h0000BEEF);
    check("mis_sh_done", 32'(done), 32'd1);
    check("mis_sh_exc", 32'(align_exc), 32'd1);
    check("mis_sh_busy", 32'(busy), 32'd0);
    tick();
`else
    check("mis_sw_wr", 32'(mem_wr), 32'd1);
    check("mis_sw_addr", mem_addr, 32'h100);
    check("mis_sw_wdata", mem_wdata, 32'hCAFEF00D);
    check("mis_sw_exc", 32'(align_exc), 32'd0);
    tick();
    check("mis_sw_done", 32'(done), 32'd1);
    check("mis_sw_exc_done", 32'(align_exc), 32'd0);
    check("mis_sw_wr_count", 32'(wr_count - wr_base), 32'd1);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end

endmodule
